// File: rtl/ip_disp_sampler.sv
// Sample-and-hold stage ahead of the hex display: tracks the instruction pointer live,
// down-samples it in turbo mode, and holds it while the debounced freeze toggle is set.
`timescale 1ns/1ps
module ip_disp_sampler #(
    parameter int SAMPLE_DIV      = 2_500_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ip_in,
    input  logic       ip_valid,
    input  logic       turbo_mode,
    input  logic       freeze_btn,
    output logic [7:0] data_out,
    output logic       turbo_out,
    output logic       frozen,
    output logic       update_pulse
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        TURBO  = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       turbo_meta_q, turbo_meta_d;
    logic       turbo_sync_q, turbo_sync_d;
    logic       turbo_out_q, turbo_out_d;
    logic       btn_meta_q, btn_meta_d;
    logic       btn_sync_q, btn_sync_d;
    logic       db_level_q, db_level_d;
    logic       db_prev_q, db_prev_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic       frozen_q, frozen_d;
    logic       was_frozen_q, was_frozen_d;
    logic [7:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0] data_q, data_d;
    logic       update_q, update_d;
    logic       load_en;
    logic [7:0] load_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= LIVE;
            turbo_meta_q <= 1'b0;
            turbo_sync_q <= 1'b0;
            turbo_out_q  <= 1'b0;
            btn_meta_q   <= 1'b0;
            btn_sync_q   <= 1'b0;
            db_level_q   <= 1'b0;
            db_prev_q    <= 1'b0;
            db_cnt_q     <= '0;
            frozen_q     <= 1'b0;
            was_frozen_q <= 1'b0;
            shadow_q     <= 8'h00;
            div_q        <= '0;
            data_q       <= 8'h00;
            update_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            turbo_meta_q <= turbo_meta_d;
            turbo_sync_q <= turbo_sync_d;
            turbo_out_q  <= turbo_out_d;
            btn_meta_q   <= btn_meta_d;
            btn_sync_q   <= btn_sync_d;
            db_level_q   <= db_level_d;
            db_prev_q    <= db_prev_d;
            db_cnt_q     <= db_cnt_d;
            frozen_q     <= frozen_d;
            was_frozen_q <= was_frozen_d;
            shadow_q     <= shadow_d;
            div_q        <= div_d;
            data_q       <= data_d;
            update_q     <= update_d;
        end
    end

    // Synchronisers, button debounce and the freeze toggle.
    always_comb begin
        turbo_meta_d = turbo_mode;
        turbo_sync_d = turbo_meta_q;
        turbo_out_d  = turbo_sync_q;
        btn_meta_d   = freeze_btn;
        btn_sync_d   = btn_meta_q;
        db_level_d   = db_level_q;
        db_cnt_d     = '0;
        if (btn_sync_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        db_prev_d = db_level_q;
        frozen_d  = frozen_q ^ (db_level_q & ~db_prev_q);
    end

    // State machine and output register; loads are suppressed whenever the next state is FROZEN,
    // so a strobe coinciding with the freeze toggle only reaches the shadow.
    always_comb begin
        state_d = LIVE;
        if (frozen_d) begin
            state_d = FROZEN;
        end else if (turbo_sync_q) begin
            state_d = TURBO;
        end
        was_frozen_d = (state_q == FROZEN);
        shadow_d     = ip_valid ? ip_in : shadow_q;

        div_d = '0;
        if (state_q == TURBO && state_d == TURBO) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end

        load_en  = 1'b0;
        load_val = ip_valid ? ip_in : shadow_q;
        if (state_d != FROZEN) begin
            case (state_q)
                LIVE:    load_en = ip_valid | was_frozen_q;
                TURBO:   load_en = was_frozen_q | (div_q == DIV_LAST);
                default: load_en = 1'b0;
            endcase
        end
        data_d   = load_en ? load_val : data_q;
        update_d = load_en;
    end

    assign data_out     = data_q;
    assign turbo_out    = turbo_out_q;
    assign frozen       = frozen_q;
    assign update_pulse = update_q;

endmodule

// File: doc/ip_disp_sampler.md
# ip_disp_sampler

Sampling and hold stage that sits directly upstream of the two-digit hex display driver. It takes the CPU instruction pointer and its update strobe, then produces a stable 8-bit value and a registered turbo flag for the display. In turbo mode the pointer changes too quickly to read, so the stage down-samples it to a readable rate. A debounced freeze button holds the displayed value on demand.

## Interface
- `SAMPLE_DIV`, 2_500_000: turbo refresh period in clock cycles (≥2); 20 Hz at 50 MHz.
- `DEBOUNCE_CYCLES`, 500_000: consecutive stable cycles required to accept a freeze-button level change (≥1).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ip_in`  in  8  current instruction pointer from the CPU.
- `ip_valid`  in  1  one-cycle strobe; `ip_in` is valid and new this cycle.
- `turbo_mode`  in  1  CPU turbo select, asynchronous to `clk`, level.
- `freeze_btn`  in  1  raw push-button, active-high, asynchronous, bouncy.
- `data_out`  out  8  value for the display (feeds display `data_in`).
- `turbo_out`  out  1  synchronised `turbo_mode` (feeds display `turbo_mode`).
- `frozen`  out  1  status LED, high while display is frozen.
- `update_pulse`  out  1  high for one cycle each time `data_out` is loaded.

## Operation
- Synchronisers: `turbo_mode` and `freeze_btn` each pass through a 2-flop synchroniser. `turbo_out` is the synchronised turbo value.
- Debounce: a counter compares the synchronised button with the debounced level. It clears on any mismatch-free cycle or level flip, and counts while they differ. At `DEBOUNCE_CYCLES` the debounced level updates and the counter clears. A debounced rising edge toggles `frozen`. Falling edges do nothing.
- Shadow register: loads `ip_in` on every `ip_valid`, in all states. It always holds the latest pointer.
- State machine: LIVE, TURBO, FROZEN. Priority is FROZEN > TURBO > LIVE, and the next state is evaluated every cycle:
  - `frozen`=1 → FROZEN.
  - Otherwise, synchronised turbo=1 → TURBO.
  - Otherwise → LIVE.
- LIVE: on `ip_valid`, `data_out` ← `ip_in`.
- TURBO: the divider counts 0..`SAMPLE_DIV`-1 and wraps. At terminal count, `data_out` ← `ip_in` if `ip_valid` that cycle, otherwise ← shadow. The divider clears to 0 on every entry to TURBO.
- FROZEN: `data_out` holds. The divider is held at 0.
- Leaving FROZEN (to LIVE or TURBO): on the first cycle in the new state, `data_out` ← shadow (or `ip_in` if `ip_valid`).
- `update_pulse` asserts on every cycle that loads `data_out`, including loads of an unchanged value.

## Timing
- Reset values: `data_out`=0x00, `turbo_out`=0, `frozen`=0, `update_pulse`=0. Shadow, divider, debounce counter, debounced level and synchroniser flops are all 0. State is LIVE.
- LIVE latency: `ip_valid` at edge N → `data_out` and `update_pulse` valid after edge N+1.
- Turbo path latency: a `turbo_mode` change is seen in state 2 cycles later (synchroniser). `turbo_out` changes in the same cycle as the state.
- TURBO loads: the first load occurs `SAMPLE_DIV` cycles after entry, then every `SAMPLE_DIV` cycles.
- Freeze latency: button stable high from cycle t → debounced at t+2+`DEBOUNCE_CYCLES` → `frozen` toggles one cycle later.
- Bounce: a button glitch shorter than `DEBOUNCE_CYCLES` produces no toggle.
- Freeze and `ip_valid` in the same cycle: shadow updates and `data_out` holds its previous value.
- Turbo change while FROZEN: no `data_out` activity. The new mode applies on unfreeze.
- Reset asserted mid-operation: all registers clear immediately, regardless of clock.

## Test plan
Test parameters are `SAMPLE_DIV`=4 and `DEBOUNCE_CYCLES`=3.
- Reset, then LIVE tracking:
  - Stimulus: `ip_valid` with `ip_in`=0x12, then 0xA5 two cycles later.
  - Required: `data_out`=0x12 then 0xA5, each 1 cycle after its strobe. `update_pulse` is high on exactly those two cycles.
- TURBO down-sampling:
  - Stimulus: `turbo_mode`=1, then `ip_valid` every cycle with `ip_in` counting 0x00..0x0F.
  - Required: `data_out` updates only every 4th cycle, and each value equals the `ip_in` strobed on the terminal cycle.
- Freeze with bounce:
  - Stimulus: `freeze_btn` pulses 1,0,1 (single cycles), then held high for 6 cycles.
  - Required: no toggle from the pulses. `frozen`=1 at 2+3+1 cycles after the stable high. `data_out` then holds through 10 further `ip_valid` strobes, last `ip_in`=0x77.
- Unfreeze:
  - Stimulus: release `freeze_btn`, then a second stable press.
  - Required: `frozen`=0, and `data_out`=0x77 with `update_pulse` on the first unfrozen cycle.
- Collision:
  - Stimulus: `ip_valid` with `ip_in`=0x3C in the same cycle `frozen` rises.
  - Required: `data_out` keeps its old value, and shows 0x3C after unfreeze.
- Async reset:
  - Stimulus: deassert `reset_n` mid-TURBO with `data_out`=0x9E.
  - Required: all outputs are 0 immediately without a clock edge. After release, state is LIVE.
